// File: rtl/pdp11_alu_pkg.sv
// Shared definitions for the PDP-11 ALU: op codes, condition-code bit positions
// and the FSM state encoding.
package pdp11_alu_pkg;

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_CMP = 4'd3;
    localparam logic [3:0] OP_BIC = 4'd4;
    localparam logic [3:0] OP_BIS = 4'd5;
    localparam logic [3:0] OP_BIT = 4'd6;
    localparam logic [3:0] OP_ASH = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8;
    localparam logic [3:0] OP_DEC = 4'd9;
    localparam logic [3:0] OP_NEG = 4'd10;
    localparam logic [3:0] OP_CLR = 4'd11;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_V = 1;
    localparam int CC_C = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/pdp11_ash_shifter.sv
// Serial arithmetic shifter for ASH: one bit per step, tracking the last bit
// shifted out and whether the sign bit ever changed during a left shift.
module pdp11_ash_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] val_in,
    input  logic [5:0]  cnt_in,
    output logic [15:0] step_val,
    output logic        step_c,
    output logic        step_v,
    output logic        last
);

    logic [15:0] val_q, val_d;
    logic [5:0]  mag_q, mag_d;
    logic        left_q, left_d;
    logic        v_q, v_d;

    // step_* are the values the register would hold after this step, so the
    // parent can retire the result on the same edge as the final step.
    always_comb begin
        step_val = left_q ? {val_q[14:0], 1'b0} : {val_q[15], val_q[15:1]};
        step_c   = left_q ? val_q[15] : val_q[0];
        step_v   = v_q | (left_q & (val_q[15] ^ val_q[14]));
        last     = (mag_q == 6'd1);
    end

    always_comb begin
        val_d  = val_q;
        mag_d  = mag_q;
        left_d = left_q;
        v_d    = v_q;
        if (load) begin
            val_d  = val_in;
            left_d = ~cnt_in[5];
            // Negating 6'b100000 yields 6'd32, the correct magnitude for -32.
            mag_d  = cnt_in[5] ? (6'd0 - cnt_in) : cnt_in;
            v_d    = 1'b0;
        end else if (step) begin
            val_d = step_val;
            mag_d = mag_q - 6'd1;
            v_d   = step_v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q  <= 16'h0000;
            mag_q  <= 6'd0;
            left_q <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            val_q  <= val_d;
            mag_q  <= mag_d;
            left_q <= left_d;
            v_q    <= v_d;
        end
    end

endmodule

// File: rtl/pdp11_alu.sv
// PDP-11 ALU with NZVC register. Single-cycle ops retire on the accepting edge;
// ASH runs serially when PDP11_ALU_ASH_EN is defined, otherwise op 7 is undefined.
module pdp11_alu
    import pdp11_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cc_we,
    input  logic [3:0]  cc_in,
    output logic [15:0] w,
    output logic        we,
    output logic        done,
    output logic        busy,
    output logic [3:0]  cc,
    output state_e      state_dbg
);

    state_e      state_q, state_d;
    logic [15:0] w_q, w_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [3:0]  cc_q, cc_d;

    logic [15:0] alu_res;
    logic        alu_wr;
    logic        alu_def;
    logic [3:0]  alu_cc;
    logic [16:0] sum;
    logic [16:0] dif;
    logic [16:0] cmp;
    logic        ash_go;

    always_comb begin
        alu_res = 16'h0000;
        alu_wr  = 1'b0;
        alu_def = 1'b1;
        alu_cc  = cc_q;
        sum     = {1'b0, b} + {1'b0, a};
        dif     = {1'b0, b} - {1'b0, a};
        cmp     = {1'b0, a} - {1'b0, b};
        case (op)
            OP_MOV: begin alu_res = a;       alu_wr = 1'b1; alu_cc[CC_V] = 1'b0; end
            OP_ADD: begin
                alu_res      = sum[15:0];
                alu_wr       = 1'b1;
                alu_cc[CC_C] = sum[16];
                alu_cc[CC_V] = (a[15] == b[15]) && (sum[15] != b[15]);
            end
            OP_SUB: begin
                alu_res      = dif[15:0];
                alu_wr       = 1'b1;
                alu_cc[CC_C] = dif[16];
                alu_cc[CC_V] = (a[15] != b[15]) && (dif[15] != b[15]);
            end
            OP_CMP: begin
                alu_res      = cmp[15:0];
                alu_cc[CC_C] = cmp[16];
                alu_cc[CC_V] = (a[15] != b[15]) && (cmp[15] != a[15]);
            end
            OP_BIC: begin alu_res = b & ~a;  alu_wr = 1'b1; alu_cc[CC_V] = 1'b0; end
            OP_BIS: begin alu_res = b | a;   alu_wr = 1'b1; alu_cc[CC_V] = 1'b0; end
            OP_BIT: begin alu_res = a & b;   alu_cc[CC_V] = 1'b0; end
`ifdef PDP11_ALU_ASH_EN
            // Only the zero-count case retires here; nonzero counts go serial.
            OP_ASH: begin
                alu_res      = b;
                alu_wr       = 1'b1;
                alu_cc[CC_V] = 1'b0;
                alu_cc[CC_C] = 1'b0;
            end
`endif
            OP_INC: begin
                alu_res      = b + 16'h0001;
                alu_wr       = 1'b1;
                alu_cc[CC_V] = (b == 16'h7FFF);
            end
            OP_DEC: begin
                alu_res      = b - 16'h0001;
                alu_wr       = 1'b1;
                alu_cc[CC_V] = (b == 16'h8000);
            end
            OP_NEG: begin
                alu_res      = 16'h0000 - b;
                alu_wr       = 1'b1;
                alu_cc[CC_V] = (alu_res == 16'h8000);
                alu_cc[CC_C] = (alu_res != 16'h0000);
            end
            OP_CLR: begin
                alu_res      = 16'h0000;
                alu_wr       = 1'b1;
                alu_cc[CC_V] = 1'b0;
                alu_cc[CC_C] = 1'b0;
            end
            default: alu_def = 1'b0;
        endcase
        if (alu_def) begin
            alu_cc[CC_N] = alu_res[15];
            alu_cc[CC_Z] = (alu_res == 16'h0000);
        end
    end

`ifdef PDP11_ALU_ASH_EN
    logic [15:0] sh_val;
    logic        sh_c;
    logic        sh_v;
    logic        sh_last;

    assign ash_go = (op == OP_ASH) && (a[5:0] != 6'd0);

    pdp11_ash_shifter u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     ((state_q == ST_IDLE) && start && ash_go),
        .step     (state_q == ST_EXEC),
        .val_in   (b),
        .cnt_in   (a[5:0]),
        .step_val (sh_val),
        .step_c   (sh_c),
        .step_v   (sh_v),
        .last     (sh_last)
    );
`else
    assign ash_go = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        cc_d    = cc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (ash_go) begin
                        state_d = ST_EXEC;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        we_d   = alu_wr;
                        if (alu_wr) w_d = alu_res;
                        if (alu_def) cc_d = alu_cc;
                    end
                end
            end
            ST_EXEC: begin
`ifdef PDP11_ALU_ASH_EN
                if (sh_last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    we_d    = 1'b1;
                    w_d     = sh_val;
                    cc_d    = {sh_val[15], (sh_val == 16'h0000), sh_v, sh_c};
                end
`else
                state_d = ST_IDLE;
                busy_d  = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // An explicit condition-code load overrides whatever the op produced.
        if (cc_we) cc_d = cc_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            w_q     <= 16'h0000;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cc_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cc_q    <= cc_d;
        end
    end

    assign w         = w_q;
    assign we        = we_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cc        = cc_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pdp11_alu.sv
// Directed testbench for pdp11_alu; ASH vectors run when PDP11_ALU_ASH_EN is
// defined, otherwise op 7 is exercised as an undefined op.
module tb_pdp11_alu;
    import pdp11_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cc_we;
    logic [3:0]  cc_in;
    logic [15:0] w;
    logic        we;
    logic        done;
    logic        busy;
    logic [3:0]  cc;
    state_e      state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    pdp11_alu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cc_we     (cc_we),
        .cc_in     (cc_in),
        .w         (w),
        .we        (we),
        .done      (done),
        .busy      (busy),
        .cc        (cc),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for exactly one edge, then drop start.
    task automatic issue(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_done(input string tag, input logic [15:0] ew, input logic ewe,
                              input logic [3:0] ecc);
        check({tag, " done"}, 16'(done), 16'd1);
        check({tag, " busy"}, 16'(busy), 16'd0);
        check({tag, " we"}, 16'(we), 16'(ewe));
        if (ewe) check({tag, " w"}, w, ew);
        check({tag, " cc"}, 16'(cc), 16'(ecc));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a     = 16'h0000;
        b     = 16'h0000;
        cc_we = 1'b0;
        cc_in = 4'b0000;
        tick();
        tick();
        reset = 1'b0;

        check("rst w", w, 16'h0000);
        check("rst we", 16'(we), 16'd0);
        check("rst done", 16'(done), 16'd0);
        check("rst busy", 16'(busy), 16'd0);
        check("rst cc", 16'(cc), 16'd0);
        check("rst state", 16'(state_dbg), 16'(ST_IDLE));

        issue(OP_ADD, 16'h0001, 16'h7FFF);
        check_done("add", 16'h8000, 1'b1, 4'b1010);
        tick();
        check("pulse done", 16'(done), 16'd0);
        check("pulse we", 16'(we), 16'd0);

        issue(OP_SUB, 16'h0001, 16'h0000);
        check_done("sub", 16'hFFFF, 1'b1, 4'b1001);
        issue(OP_MOV, 16'h0000, 16'h1234);
        check_done("mov", 16'h0000, 1'b1, 4'b0101);
        issue(OP_CMP, 16'h0005, 16'h0005);
        check_done("cmp", 16'h0000, 1'b0, 4'b0100);
        issue(OP_BIC, 16'h00FF, 16'h0F0F);
        check_done("bic", 16'h0F00, 1'b1, 4'b0000);
        issue(OP_BIS, 16'h8000, 16'h0001);
        check_done("bis", 16'h8001, 1'b1, 4'b1000);
        issue(OP_BIT, 16'h00F0, 16'h0F00);
        check_done("bit", 16'h0000, 1'b0, 4'b0100);
        issue(OP_NEG, 16'h0000, 16'h0001);
        check_done("neg1", 16'hFFFF, 1'b1, 4'b1001);
        issue(OP_NEG, 16'h0000, 16'h8000);
        check_done("neg8000", 16'h8000, 1'b1, 4'b1011);
        issue(OP_CLR, 16'hFFFF, 16'hFFFF);
        check_done("clr", 16'h0000, 1'b1, 4'b0100);
        issue(OP_DEC, 16'h0000, 16'h8000);
        check_done("dec", 16'h7FFF, 1'b1, 4'b0010);

        cc_we = 1'b1;
        cc_in = 4'b0101;
        issue(OP_INC, 16'h0000, 16'h7FFF);
        cc_we = 1'b0;
        check_done("inc+ccwe", 16'h8000, 1'b1, 4'b0101);

        cc_we = 1'b1;
        cc_in = 4'b1111;
        tick();
        cc_we = 1'b0;
        check("ccwe idle", 16'(cc), 16'hF);

        issue(4'd14, 16'h1111, 16'h2222);
        check_done("op14", 16'h0000, 1'b0, 4'b1111);

`ifdef PDP11_ALU_ASH_EN
        issue(OP_ASH, 16'h0003, 16'h0011);
        check("ash3 busy1", 16'(busy), 16'd1);
        check("ash3 done1", 16'(done), 16'd0);
        check("ash3 state", 16'(state_dbg), 16'(ST_EXEC));
        tick();
        check("ash3 busy2", 16'(busy), 16'd1);
        tick();
        check("ash3 busy3", 16'(busy), 16'd1);
        check("ash3 done3", 16'(done), 16'd0);
        tick();
        check_done("ash3", 16'h0088, 1'b1, 4'b0000);

        issue(OP_ASH, 16'h003F, 16'h8001);
        check("ashm1 done1", 16'(done), 16'd0);
        tick();
        check_done("ashm1", 16'hC000, 1'b1, 4'b1001);

        issue(OP_ASH, 16'h0001, 16'h4000);
        tick();
        check_done("ash vflag", 16'h8000, 1'b1, 4'b1010);

        issue(OP_ASH, 16'h0000, 16'h8000);
        check_done("ash0", 16'h8000, 1'b1, 4'b1000);

        // Keep start high for the whole ASH; only the first request and the
        // one coinciding with the done cycle may be accepted.
        op    = OP_ASH;
        a     = 16'h0004;
        b     = 16'h0001;
        start = 1'b1;
        tick();
        op    = OP_MOV;
        a     = 16'hFFFF;
        tick();
        check("hold busy", 16'(busy), 16'd1);
        tick();
        tick();
        check("hold no done", 16'(done), 16'd0);
        tick();
        check_done("hold ash4", 16'h0010, 1'b1, 4'b0000);
        tick();
        start = 1'b0;
        check_done("b2b mov", 16'hFFFF, 1'b1, 4'b1000);

        issue(OP_ASH, 16'h0005, 16'h1234);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 16'(busy), 16'd0);
        check("abort done", 16'(done), 16'd0);
        check("abort we", 16'(we), 16'd0);
        check("abort cc", 16'(cc), 16'd0);
        check("abort state", 16'(state_dbg), 16'(ST_IDLE));
        tick();
        check("abort done2", 16'(done), 16'd0);
        issue(OP_ASH, 16'h003E, 16'h8003);
        tick();
        check("ashm2 done2", 16'(done), 16'd0);
        tick();
        check_done("ashm2", 16'hE000, 1'b1, 4'b1001);
`else
        issue(OP_ASH, 16'h0003, 16'h0011);
        check_done("op7 undef", 16'h0000, 1'b0, 4'b1111);
        tick();
        check("op7 busy after", 16'(busy), 16'd0);
        check("op7 done after", 16'(done), 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
